pid_steer: RTL and testbench
============================

Name: pid_steer

Overview:
Closed-loop steering controller directly upstream of the motor driver. It consumes a signed heading error and a forward-speed command, and computes a PID correction. It produces the signed 12-bit lft_spd/rght_spd words that the motor driver scales and converts to PWM. The datapath is a two-stage registered pipeline advanced by err_vld, with a saturating integrator and a sample-delay derivative.

Parameters:
P_COEFF, 3, signed 6-bit proportional gain
D_COEFF, 7, signed 5-bit derivative gain
D_QUEUE_DEPTH, 2, number of err_vld samples back used for the derivative (>=1)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
error  input  12  signed heading error
err_vld  input  1  one-cycle strobe; error is valid this cycle
frwrd  input  11  unsigned forward-speed command
moving  input  1  high while the robot is permitted to move
lft_spd  output  12  signed left speed command to the motor driver
rght_spd  output  12  signed right speed command to the motor driver
spd_vld  output  1  one-cycle strobe; lft_spd/rght_spd updated

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high (rst). On rst all registers, the integrator and the D queue clear to 0, and lft_spd=rght_spd=0, spd_vld=0. Reset asserted mid-pipeline discards any in-flight sample.
- err_sat: error saturated to signed 10 bits, range -512..511. Any error above 511 gives 511; any error below -512 gives -512.
- Stage 1 registers the terms on a clk edge with err_vld=1.
  - P = err_sat*P_COEFF, 14-bit signed.
  - integ is an 18-bit signed accumulator. Next value = integ + sign-extended err_sat, computed only when err_vld && moving.
  - If that addition overflows (operand signs equal, result sign differs), integ holds its value instead of wrapping.
  - I = next-integ[17:6], sign-extended to 14 bits. Stage 1 uses the updated integ value.
  - D: diff = err_sat minus the sample D_QUEUE_DEPTH err_vld strobes earlier. diff is saturated to signed 7 bits (-64..63), then multiplied by D_COEFF and sign-extended to 14 bits.
  - The queue shifts only on err_vld and holds zeros after reset.
- Stage 2 registers the outputs one cycle after stage 1.
  - pid = P+I+D (14-bit; cannot overflow with the defaults). corr = pid>>>3 (arithmetic shift).
  - lft_spd = sat12(zext(frwrd)+corr); rght_spd = sat12(zext(frwrd)-corr). sat12 clamps to the range -2048..2047.
  - spd_vld pulses exactly one cycle per accepted err_vld.
- Latency: error sampled at edge N; lft_spd/rght_spd/spd_vld visible after edge N+1. Back-to-back err_vld on consecutive cycles is fully pipelined.
- moving=0 has the following effects:
  - integ clears on the next edge, and that edge suppresses the accumulate.
  - Stage-2 outputs become 0 on the next edge regardless of err_vld.
  - The D queue still shifts on err_vld.
- err_vld=0: all registers hold; spd_vld=0.

Optional Feature:
PID_DTERM_EN
- Defined: the D term is built as specified, including the D_QUEUE_DEPTH delay queue.
- Undefined: the D term is the constant 0, no queue registers are instantiated, and D_COEFF/D_QUEUE_DEPTH are unused. pid = P+I.

Decomposition:
- Package pid_pkg holds:
  - width constants: ERR_W=12, ERR_SAT_W=10, INTEG_W=18, PID_W=14, SPD_W=12, FRWRD_W=11;
  - typedefs err_t, spd_t, pid_t;
  - a pure function sat_signed(value, width) used for the 10-, 7- and 12-bit clamps.
- One sub-module is natural: pid_integrator, which contains the 18-bit accumulator with overflow hold, the clear-on-not-moving rule, and the I-term extraction.

Test Plan:
- Idle case: rst then moving=1, frwrd=0x200, error=0, one err_vld -> two cycles later lft_spd=rght_spd=512, spd_vld high for one cycle.
- First large error (PID_DTERM_EN on): from the idle state, error=12'h7FF, one err_vld -> err_sat=511, P=1533, I=7, D=441, corr=247; lft_spd=759, rght_spd=265.
- Output clamp: frwrd=0x7FF, error=12'h7FF -> lft_spd=2047 (clamped), rght_spd=1800.
- Integrator overflow hold: hold error=12'h7FF for 300 err_vld strobes with moving=1 -> integ never wraps negative and stays at or below 131071.
  - Same case, I term: I saturates at 2047.
  - Same case, later samples: lft_spd never decreases between successive spd_vld pulses.
- moving drop: moving=0 mid-stream with err_vld active -> the next edge gives lft_spd=rght_spd=0 and integ=0.
  - Resume: after moving returns to 1, the first sample's I equals err_sat>>6.
- Reset mid-flight: rst asserted on the cycle after err_vld -> no spd_vld pulse, outputs 0, and the D queue is zeroed.
  - Verify the queue: the next error=0x100 gives D=63*7=441 with the D term enabled.

Source files
------------

// File: rtl/pid_pkg.sv
// ---------------------------------------------------------------------------
// pid_pkg
// Shared widths, datapath types and the saturation helper used by the
// pid_steer steering controller and its integrator.
//
// Contents:
//   ERR_W / ERR_SAT_W / INTEG_W / PID_W / SPD_W / FRWRD_W : datapath widths
//   SAT_W                 : working width of the saturation helper
//   err_t, spd_t, pid_t   : signed datapath word types
//   sat_signed(v, w)      : clamp a signed value to the signed range of w bits
// ---------------------------------------------------------------------------
package pid_pkg;

  localparam int ERR_W     = 12;
  localparam int ERR_SAT_W = 10;
  localparam int INTEG_W   = 18;
  localparam int PID_W     = 14;
  localparam int SPD_W     = 12;
  localparam int FRWRD_W   = 11;

  // Every value that gets clamped (error, error difference, speed sums)
  // fits comfortably in 16 signed bits, so one helper width covers them all.
  localparam int SAT_W = 16;

  typedef logic signed [ERR_W-1:0] err_t;
  typedef logic signed [SPD_W-1:0] spd_t;
  typedef logic signed [PID_W-1:0] pid_t;

  // Clamp a signed value into -(2**(width-1)) .. 2**(width-1)-1.
  // The result stays SAT_W wide; callers size-cast it to the target width,
  // which is lossless because the value is already inside that range.
  function automatic logic signed [SAT_W-1:0] sat_signed(
    input logic signed [SAT_W-1:0] value,
    input int                      width
  );
    int v;
    int hi;
    int lo;
    v  = int'(value);
    hi = (1 << (width - 1)) - 1;
    lo = -(1 << (width - 1));
    if (v > hi) begin
      return SAT_W'(hi);
    end
    if (v < lo) begin
      return SAT_W'(lo);
    end
    return value;
  endfunction

endpackage

// File: rtl/pid_integrator.sv
// ---------------------------------------------------------------------------
// pid_integrator
// 18-bit signed accumulator of the saturated heading error for the I term.
// An addition that would overflow leaves the accumulator unchanged, and the
// accumulator is cleared whenever the robot is not permitted to move.
//
// Ports:
//   clk        : system clock
//   rst        : synchronous active-high reset, clears the accumulator
//   en_i       : error strobe; accumulate this cycle
//   moving_i   : high while the robot may move; low clears the accumulator
//   err_sat_i  : error already clamped to signed 10 bits
//   i_term_o   : I term derived from the accumulator value being loaded this
//                cycle (upper 12 bits, sign-extended to the PID width)
// ---------------------------------------------------------------------------
module pid_integrator
  import pid_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en_i,
  input  logic                        moving_i,
  input  logic signed [ERR_SAT_W-1:0] err_sat_i,
  output pid_t                        i_term_o
);

  localparam int I_SHIFT = 6;

  logic signed [INTEG_W-1:0] integ_q;
  logic signed [INTEG_W-1:0] integ_d;
  logic signed [INTEG_W-1:0] err_ext;
  logic signed [INTEG_W-1:0] sum;
  logic                      ovf;

  assign err_ext = INTEG_W'(err_sat_i);
  assign sum     = integ_q + err_ext;

  // Two's-complement overflow: operands share a sign but the sum does not.
  assign ovf = (integ_q[INTEG_W-1] == err_ext[INTEG_W-1]) &&
               (sum[INTEG_W-1] != integ_q[INTEG_W-1]);

  // Not moving wins over accumulation; an overflowing add simply holds.
  always_comb begin
    integ_d = integ_q;
    if (!moving_i) begin
      integ_d = '0;
    end else if (en_i && !ovf) begin
      integ_d = sum;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (rst) begin
      integ_q <= '0;
    end else begin
      integ_q <= integ_d;
    end
  end

  // The I term follows the freshly updated value so a sample sees its own
  // contribution in the same pipeline stage.
  assign i_term_o = PID_W'($signed(integ_d[INTEG_W-1:I_SHIFT]));

endmodule

// File: rtl/pid_steer.sv
// ---------------------------------------------------------------------------
// pid_steer
// Closed-loop steering controller feeding the motor driver. A signed heading
// error is turned into a PID correction that is added to / subtracted from
// the forward-speed command to give the left / right wheel speeds.
// Two registered stages: stage 1 captures P, I and D on err_vld, stage 2
// forms the clamped wheel speeds one clock later and pulses spd_vld.
//
// Build option:
//   PID_DTERM_EN : when defined, the derivative term (error minus the sample
//                  D_QUEUE_DEPTH strobes earlier) is built with its delay
//                  queue; when undefined the D term is zero and no queue
//                  registers exist.
//
// Ports:
//   clk      : system clock
//   rst      : synchronous active-high reset
//   error    : signed 12-bit heading error
//   err_vld  : one-cycle strobe, error valid
//   frwrd    : unsigned 11-bit forward-speed command
//   moving   : high while the robot may move
//   lft_spd  : signed 12-bit left speed command
//   rght_spd : signed 12-bit right speed command
//   spd_vld  : one-cycle strobe, speed outputs updated
// ---------------------------------------------------------------------------
module pid_steer
  import pid_pkg::*;
#(
  parameter logic signed [5:0] P_COEFF       = 6'sd3,
  parameter logic signed [4:0] D_COEFF       = 5'sd7,
  parameter int                D_QUEUE_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  err_t               error,
  input  logic               err_vld,
  input  logic [FRWRD_W-1:0] frwrd,
  input  logic               moving,
  output spd_t               lft_spd,
  output spd_t               rght_spd,
  output logic               spd_vld
);

  logic signed [ERR_SAT_W-1:0] err_sat;
  pid_t                        p_d;
  pid_t                        i_term;

  logic                        vld1_q;
  pid_t                        p_q;
  pid_t                        i_q;

  pid_t                        pid;
  pid_t                        corr;
  logic signed [SAT_W-1:0]     fw_ext;
  logic signed [SAT_W-1:0]     lft_sum;
  logic signed [SAT_W-1:0]     rght_sum;
  spd_t                        lft_d;
  spd_t                        rght_d;

  spd_t                        lft_q;
  spd_t                        rght_q;
  logic                        vld2_q;

  assign err_sat = ERR_SAT_W'(sat_signed(SAT_W'(error), ERR_SAT_W));
  assign p_d     = pid_t'(err_sat) * pid_t'(P_COEFF);

  pid_integrator u_integ (
    .clk       (clk),
    .rst       (rst),
    .en_i      (err_vld),
    .moving_i  (moving),
    .err_sat_i (err_sat),
    .i_term_o  (i_term)
  );

`ifdef PID_DTERM_EN
  localparam int DIFF_W     = ERR_SAT_W + 1;
  localparam int DIFF_SAT_W = 7;

  logic signed [ERR_SAT_W-1:0]  dq_q [D_QUEUE_DEPTH];
  logic signed [DIFF_W-1:0]     diff;
  logic signed [DIFF_SAT_W-1:0] diff_sat;
  pid_t                         d_d;
  pid_t                         d_q;

  // The difference is taken one bit wider so it cannot wrap before clamping.
  assign diff     = DIFF_W'(err_sat) - DIFF_W'(dq_q[D_QUEUE_DEPTH-1]);
  assign diff_sat = DIFF_SAT_W'(sat_signed(SAT_W'(diff), DIFF_SAT_W));
  assign d_d      = pid_t'(diff_sat) * pid_t'(D_COEFF);

  // Sample history for the derivative. It advances on every error strobe,
  // including while not moving, so the history stays aligned with the error
  // stream rather than with the motion state.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < D_QUEUE_DEPTH; k++) begin
        dq_q[k] <= '0;
      end
    end else if (err_vld) begin
      dq_q[0] <= err_sat;
      for (int k = 1; k < D_QUEUE_DEPTH; k++) begin
        dq_q[k] <= dq_q[k-1];
      end
    end
  end

  // Stage-1 register for the D term, captured alongside P and I.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_q <= '0;
    end else if (err_vld) begin
      d_q <= d_d;
    end
  end

  assign pid = p_q + i_q + d_q;
`else
  assign pid = p_q + i_q;
`endif

  // Stage 1: capture P and I on the strobe; the valid bit follows the strobe
  // so that exactly one stage-2 update happens per accepted sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld1_q <= 1'b0;
      p_q    <= '0;
      i_q    <= '0;
    end else begin
      vld1_q <= err_vld;
      if (err_vld) begin
        p_q <= p_d;
        i_q <= i_term;
      end
    end
  end

  // Correction and wheel-speed sums, all in a wide signed domain so that
  // only the final clamp limits the range.
  assign corr     = pid >>> 3;
  assign fw_ext   = SAT_W'($signed({1'b0, frwrd}));
  assign lft_sum  = fw_ext + SAT_W'(corr);
  assign rght_sum = fw_ext - SAT_W'(corr);
  assign lft_d    = SPD_W'(sat_signed(lft_sum, SPD_W));
  assign rght_d   = SPD_W'(sat_signed(rght_sum, SPD_W));

  // Stage 2: dropping moving forces the wheels to zero on the next edge,
  // whether or not a sample is arriving; otherwise speeds update only when
  // stage 1 holds a fresh sample and hold in between.
  always_ff @(posedge clk) begin
    if (rst) begin
      lft_q  <= '0;
      rght_q <= '0;
      vld2_q <= 1'b0;
    end else begin
      vld2_q <= vld1_q;
      if (!moving) begin
        lft_q  <= '0;
        rght_q <= '0;
      end else if (vld1_q) begin
        lft_q  <= lft_d;
        rght_q <= rght_d;
      end
    end
  end

  assign lft_spd  = lft_q;
  assign rght_spd = rght_q;
  assign spd_vld  = vld2_q;

endmodule

// File: tb/tb_pid_steer.sv
// ---------------------------------------------------------------------------
// tb_pid_steer
// Scoreboard bench for pid_steer. Stimulus pushes the expected wheel speeds
// for every accepted error sample; an independent negedge monitor pops and
// compares whenever spd_vld is high. Key vectors carry hand-computed values,
// long runs use a small behavioural model kept in the bench.
// Define PID_DTERM_EN for both the bench and the design to exercise the
// derivative build.
// ---------------------------------------------------------------------------
module tb_pid_steer;

  localparam int DQ      = 2;
  localparam int K_MODEL = 0;
  localparam int K_HAND  = 1;
  localparam int K_ZERO  = 2;
  localparam int K_NONE  = 3;

`ifdef PID_DTERM_EN
  localparam int LARGE_L = 759;
  localparam int LARGE_R = 265;
  localparam int CLAMP_R = 1800;
  localparam int RESUME_L = 407;
  localparam int RESUME_R = 105;
  localparam int POST_C  = 151;
`else
  localparam int LARGE_L = 704;
  localparam int LARGE_R = 320;
  localparam int CLAMP_R = 1855;
  localparam int RESUME_L = 352;
  localparam int RESUME_R = 160;
  localparam int POST_C  = 96;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] error;
  logic        err_vld;
  logic [10:0] frwrd;
  logic        moving;
  logic [11:0] lft_spd;
  logic [11:0] rght_spd;
  logic        spd_vld;

  int total = 0;
  int bad   = 0;

  int expL[$];
  int expR[$];

  int integM;
  int qM [DQ];

  logic zeroReq  = 1'b0;
  logic holdReq  = 1'b0;
  logic drainReq = 1'b0;
  logic runActive = 1'b0;

  int lastExpL = 0;
  int lastExpR = 0;
  int runCount = 0;
  int prevL    = 0;

  pid_steer dut (
    .clk      (clk),
    .rst      (rst),
    .error    (error),
    .err_vld  (err_vld),
    .frwrd    (frwrd),
    .moving   (moving),
    .lft_spd  (lft_spd),
    .rght_spd (rght_spd),
    .spd_vld  (spd_vld)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Hard stop in case the stimulus ever wedges.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before 200000ns");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int satv(input int v, input int lo, input int hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic checkAtLeast(input string name, input int act, input int floor);
    total++;
    if (act < floor) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected at least %0d", name, act, floor);
    end
  endtask

  task automatic modelReset();
    integM = 0;
    for (int k = 0; k < DQ; k++) qM[k] = 0;
  endtask

  // Behavioural model of one accepted sample, returning the correction.
  task automatic modelStep(input logic [11:0] e, output int corr);
    int es;
    int p;
    int i;
    int d;
    int sum;
    int diff;
    es = satv(int'($signed(e)), -512, 511);
    p  = es * 3;
    if (moving) begin
      sum = integM + es;
      if (sum <= 131071 && sum >= -131072) integM = sum;
    end else begin
      integM = 0;
    end
    i    = integM >>> 6;
    d    = 0;
    diff = 0;
`ifdef PID_DTERM_EN
    diff = satv(es - qM[DQ-1], -64, 63);
    d    = diff * 7;
    for (int k = DQ - 1; k > 0; k--) qM[k] = qM[k-1];
    qM[0] = es;
`endif
    corr = (p + i + d) >>> 3;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issue one error sample and record what the monitor should see for it.
  task automatic applyStimulus(input logic [11:0] e, input int kind,
                               input int hL, input int hR);
    int corr;
    int mL;
    int mR;
    modelStep(e, corr);
    mL = satv(int'(frwrd) + corr, -2048, 2047);
    mR = satv(int'(frwrd) - corr, -2048, 2047);
    case (kind)
      K_MODEL: begin expL.push_back(mL); expR.push_back(mR); end
      K_HAND:  begin expL.push_back(hL); expR.push_back(hR); end
      K_ZERO:  begin expL.push_back(0);  expR.push_back(0);  end
      default: ;
    endcase
    error   = e;
    err_vld = 1'b1;
    @(posedge clk);
    #1;
    err_vld = 1'b0;
  endtask

  // Monitor: the only process that makes comparisons.
  always @(negedge clk) begin
    if (spd_vld === 1'b1) begin
      if (expL.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_spd_vld: got pulse, expected none");
      end else begin
        int eL;
        int eR;
        eL = expL.pop_front();
        eR = expR.pop_front();
        checkOutput("lft_spd", int'($signed(lft_spd)), eL);
        checkOutput("rght_spd", int'($signed(rght_spd)), eR);
        lastExpL = eL;
        lastExpR = eR;
        if (runActive) begin
          runCount++;
          if (runCount > 3) checkAtLeast("lft_monotonic", int'($signed(lft_spd)), prevL);
          prevL = int'($signed(lft_spd));
        end
      end
    end
    if (zeroReq) begin
      checkOutput("zero_lft", int'($signed(lft_spd)), 0);
      checkOutput("zero_rght", int'($signed(rght_spd)), 0);
      checkOutput("zero_vld", (spd_vld === 1'b0) ? 0 : 1, 0);
    end
    if (holdReq) begin
      checkOutput("hold_lft", int'($signed(lft_spd)), lastExpL);
      checkOutput("hold_rght", int'($signed(rght_spd)), lastExpR);
    end
    if (drainReq) begin
      checkOutput("pending_samples", expL.size(), 0);
    end
  end

  initial begin
    rst     = 1'b1;
    err_vld = 1'b0;
    moving  = 1'b0;
    error   = 12'h000;
    frwrd   = 11'h000;
    modelReset();

    // Reset state.
    idle(2);
    zeroReq = 1'b1;
    @(negedge clk);
    #1;
    zeroReq = 1'b0;
    rst = 1'b0;
    modelReset();

    // Zero error, then a first large error.
    moving = 1'b1;
    frwrd  = 11'h200;
    applyStimulus(12'h000, K_HAND, 512, 512);
    idle(2);
    applyStimulus(12'h7FF, K_HAND, LARGE_L, LARGE_R);
    idle(2);

    // Output clamp from a fresh state.
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    modelReset();
    frwrd = 11'h7FF;
    applyStimulus(12'h7FF, K_HAND, 2047, CLAMP_R);
    idle(2);

    // Long back-to-back run that drives the integrator into overflow hold.
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    modelReset();
    frwrd = 11'h000;
    runActive = 1'b1;
    for (int n = 0; n < 300; n++) applyStimulus(12'h7FF, K_MODEL, 0, 0);
    idle(2);
    runActive = 1'b0;

    // Drop moving while samples are streaming, then resume.
    frwrd = 11'h100;
    applyStimulus(12'h040, K_ZERO, 0, 0);
    moving = 1'b0;
    applyStimulus(12'h040, K_ZERO, 0, 0);
    idle(1);
    moving = 1'b1;
    idle(1);
    applyStimulus(12'h100, K_HAND, RESUME_L, RESUME_R);
    idle(2);

    // Reset on the cycle after a strobe drops that sample.
    applyStimulus(12'h100, K_MODEL, 0, 0);
    applyStimulus(12'h100, K_NONE, 0, 0);
    rst = 1'b1;
    idle(1);
    zeroReq = 1'b1;
    @(negedge clk);
    #1;
    zeroReq = 1'b0;
    idle(1);
    rst = 1'b0;
    modelReset();
    frwrd = 11'h000;
    applyStimulus(12'h100, K_HAND, POST_C, -POST_C);
    idle(2);

    // Negative and small errors with gaps, then a hold check.
    frwrd = 11'h050;
    applyStimulus(12'h800, K_MODEL, 0, 0);
    idle(1);
    applyStimulus(12'hE00, K_MODEL, 0, 0);
    applyStimulus(12'h1FF, K_MODEL, 0, 0);
    idle(3);
    applyStimulus(12'h005, K_MODEL, 0, 0);
    idle(3);
    holdReq = 1'b1;
    @(negedge clk);
    #1;
    holdReq = 1'b0;

    // Every pushed sample must have been presented.
    for (int w = 0; w < 20 && expL.size() != 0; w++) @(posedge clk);
    #1;
    drainReq = 1'b1;
    @(negedge clk);
    #1;
    drainReq = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
